// File: rtl/lfr_pkg.sv
// Shared types and helpers for the line-following controller: FSM state codes,
// motor pin codes, sensor patterns and the steering/duty helper functions.
package lfr_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FOLLOW = 3'd1,
        TURN_L = 3'd2,
        TURN_R = 3'd3,
        SEARCH = 3'd4,
        NODE   = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam logic [1:0] MOT_FWD = 2'b10;
    localparam logic [1:0] MOT_REV = 2'b01;
    localparam logic [1:0] MOT_BRK = 2'b00;

    localparam logic [2:0] SNS_NONE   = 3'b000;
    localparam logic [2:0] SNS_CENTRE = 3'b010;
    localparam logic [2:0] SNS_ALL    = 3'b111;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    localparam logic [6:0] DUTY_MAX = 7'd100;

    function automatic logic [6:0] clamp_duty(input int unsigned duty);
        if (duty > 32'd100) begin
            clamp_duty = DUTY_MAX;
        end else begin
            clamp_duty = 7'(duty);
        end
    endfunction

    // Steering decision shared by FOLLOW, TURN_L and TURN_R.
    function automatic state_t track_next(input logic [2:0] s);
        case (s)
            3'b010, 3'b101: track_next = FOLLOW;
            3'b100, 3'b110: track_next = TURN_L;
            3'b001, 3'b011: track_next = TURN_R;
            3'b111:         track_next = NODE;
            default:        track_next = SEARCH;
        endcase
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus per-bit tick-based debounce: a bit is accepted only after
// the synced value has differed from the accepted value on DEBOUNCE_TICKS consecutive ticks.
module sensor_debounce #(
    parameter int WIDTH          = 3,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);
    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt [WIDTH];

    // Synchroniser for the asynchronous sensor inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Per-bit agreement counters; any tick that agrees with the accepted value restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_TICKS - 1)) begin
                    r_stable[i] <= r_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following decision stage: tick prescaler, debounced sensors, steering FSM,
// junction counter and lost-line flag, with registered motor/duty commands.
module line_follow_ctrl
    import lfr_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int LOST_TIMEOUT   = 500,
    parameter int NODE_HOLD      = 200,
    parameter int DUTY_FWD       = 90,
    parameter int DUTY_TURN      = 60
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] sensor,
    output logic       l1,
    output logic       l2,
    output logic       r1,
    output logic       r2,
    output logic [6:0] duty_cycle,
    output logic [7:0] node_count,
    output logic       lost,
    output logic [2:0] state_dbg
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LCW      = $clog2(LOST_TIMEOUT + 1);
    localparam int HCW      = $clog2(NODE_HOLD + 1);
    localparam logic [6:0] DUTY_FWD_C  = clamp_duty(DUTY_FWD);
    localparam logic [6:0] DUTY_TURN_C = clamp_duty(DUTY_TURN);

    logic [PW-1:0]  r_presc;
    logic           w_tick;
    logic [2:0]     w_s;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [LCW-1:0] r_lost_cnt;
    logic [HCW-1:0] r_hold_cnt;
    logic [7:0]     r_node_cnt;
    logic           r_lost;
    logic           r_last_dir;
    logic [1:0]     w_mot_l;
    logic [1:0]     w_mot_r;
    logic [6:0]     w_duty;
    logic [1:0]     r_mot_l;
    logic [1:0]     r_mot_r;
    logic [6:0]     r_duty;

    // Decision tick prescaler.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    sensor_debounce #(
        .WIDTH          (3),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
        .clk      (clk_50),
        .rst_n    (rst_n),
        .i_tick   (w_tick),
        .i_raw    (sensor),
        .o_stable (w_s)
    );

    // Next-state and motor command decode; dropping enable overrides the tick gating.
    always_comb begin
        w_state_nxt = r_state;
        w_mot_l     = MOT_BRK;
        w_mot_r     = MOT_BRK;
        w_duty      = 7'd0;

        if (!enable) begin
            w_state_nxt = IDLE;
        end else if (w_tick) begin
            case (r_state)
                IDLE:                   w_state_nxt = FOLLOW;
                FOLLOW, TURN_L, TURN_R: w_state_nxt = track_next(w_s);
                SEARCH: begin
                    if (w_s != SNS_NONE) begin
                        w_state_nxt = FOLLOW;
                    end else if (r_lost_cnt == LCW'(LOST_TIMEOUT - 1)) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_state_nxt = SEARCH;
                    end
                end
                NODE: begin
                    if (r_hold_cnt == HCW'(NODE_HOLD - 1)) begin
                        w_state_nxt = FOLLOW;
                    end else begin
                        w_state_nxt = NODE;
                    end
                end
                STOP:    w_state_nxt = STOP;
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end

        case (r_state)
            FOLLOW, NODE: begin
                w_mot_l = MOT_FWD;
                w_mot_r = MOT_FWD;
                w_duty  = DUTY_FWD_C;
            end
            TURN_L: begin
                w_mot_l = MOT_BRK;
                w_mot_r = MOT_FWD;
                w_duty  = DUTY_TURN_C;
            end
            TURN_R: begin
                w_mot_l = MOT_FWD;
                w_mot_r = MOT_BRK;
                w_duty  = DUTY_TURN_C;
            end
            SEARCH: begin
                if (r_last_dir == DIR_R) begin
                    w_mot_l = MOT_FWD;
                    w_mot_r = MOT_REV;
                end else begin
                    w_mot_l = MOT_REV;
                    w_mot_r = MOT_FWD;
                end
                w_duty = DUTY_TURN_C;
            end
            default: begin
                w_mot_l = MOT_BRK;
                w_mot_r = MOT_BRK;
                w_duty  = 7'd0;
            end
        endcase
    end

    // State, dwell counters, junction count, lost flag and last turn direction.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lost_cnt <= '0;
            r_hold_cnt <= '0;
            r_node_cnt <= 8'd0;
            r_lost     <= 1'b0;
            r_last_dir <= DIR_L;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state) begin
                r_lost_cnt <= '0;
                r_hold_cnt <= '0;
            end else if (w_tick && r_state == SEARCH) begin
                r_lost_cnt <= r_lost_cnt + 1'b1;
            end else if (w_tick && r_state == NODE) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if (w_state_nxt == NODE && r_state != NODE && r_node_cnt != 8'd255) begin
                r_node_cnt <= r_node_cnt + 8'd1;
            end

            if (r_state == IDLE) begin
                r_lost <= 1'b0;
            end else if (r_state == SEARCH && w_state_nxt == STOP) begin
                r_lost <= 1'b1;
            end

            if (w_state_nxt == TURN_L) begin
                r_last_dir <= DIR_L;
            end else if (w_state_nxt == TURN_R) begin
                r_last_dir <= DIR_R;
            end
        end
    end

    // Motor and duty commands follow the state by one clock.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_mot_l <= MOT_BRK;
            r_mot_r <= MOT_BRK;
            r_duty  <= 7'd0;
        end else begin
            r_mot_l <= w_mot_l;
            r_mot_r <= w_mot_r;
            r_duty  <= w_duty;
        end
    end

    assign {l1, l2}   = r_mot_l;
    assign {r1, r2}   = r_mot_r;
    assign duty_cycle = r_duty;
    assign node_count = r_node_cnt;
    assign lost       = r_lost;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scenario bench for line_follow_ctrl: expected motor/duty changes are queued when stimulus
// is driven and popped by a monitor whenever the DUT outputs change.
module tb_line_follow_ctrl;
    import lfr_pkg::*;

    localparam int TICK_CLKS = 10;
    localparam int HOLD_T    = 5;
    localparam int LOST_T    = 8;

    localparam logic [10:0] EXP_ZERO   = {4'b0000, 7'd0};
    localparam logic [10:0] EXP_FOLLOW = {4'b1010, 7'd90};
    localparam logic [10:0] EXP_TURN_L = {4'b0010, 7'd60};
    localparam logic [10:0] EXP_TURN_R = {4'b1000, 7'd60};
    localparam logic [10:0] EXP_PIV_L  = {4'b0110, 7'd60};
    localparam logic [10:0] EXP_PIV_R  = {4'b1001, 7'd60};

    typedef struct {
        string       name;
        logic [10:0] val;
    } exp_t;

    logic       clk_50 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] sensor = 3'b010;
    logic       l1, l2, r1, r2, lost;
    logic [6:0] duty_cycle;
    logic [7:0] node_count;
    logic [2:0] state_dbg;

    exp_t        sb_q[$];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          inv_viol  = 0;
    bit          mon_en    = 1'b0;
    logic [10:0] mon_prev  = '0;

    line_follow_ctrl #(
        .CLK_HZ         (1000),
        .TICK_HZ        (100),
        .DEBOUNCE_TICKS (2),
        .LOST_TIMEOUT   (LOST_T),
        .NODE_HOLD      (HOLD_T),
        .DUTY_FWD       (90),
        .DUTY_TURN      (60)
    ) dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .enable     (enable),
        .sensor     (sensor),
        .l1         (l1),
        .l2         (l2),
        .r1         (r1),
        .r2         (r2),
        .duty_cycle (duty_cycle),
        .node_count (node_count),
        .lost       (lost),
        .state_dbg  (state_dbg)
    );

    always #5 clk_50 = ~clk_50;

    // Monitor: every change of the motor/duty vector must match the next queued expectation.
    always @(negedge clk_50) begin
        logic [10:0] cur;
        exp_t        e;
        cur = {l1, l2, r1, r2, duty_cycle};
        if (rst_n === 1'b1 && ((l1 & l2) === 1'b1 || (r1 & r2) === 1'b1 || duty_cycle > 7'd100)) begin
            inv_viol++;
        end
        if (mon_en && cur !== mon_prev) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got %b/%0d expected no change", cur[10:7], cur[6:0]);
            end else begin
                e = sb_q.pop_front();
                if (cur !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %b/%0d expected %b/%0d", e.name, cur[10:7], cur[6:0],
                             e.val[10:7], e.val[6:0]);
                end
            end
        end
        mon_prev = cur;
    end

    task automatic sb_push(input string n, input logic [10:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TICK_CLKS) @(negedge clk_50);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_50);
        n_tests++;
        if ({l1, l2, r1, r2, duty_cycle, node_count, lost, state_dbg} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b/%0d node=%0d lost=%b st=%0d expected all 0",
                     {l1, l2, r1, r2}, duty_cycle, node_count, lost, state_dbg);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_ticks(4);
        sb_push("enable_follow", EXP_FOLLOW);
        enable = 1'b1;
        wait_ticks(4);
        n_tests++;
        if (state_dbg !== FOLLOW) begin
            n_fail++;
            $display("FAIL enable_state: got %0d expected %0d", state_dbg, FOLLOW);
        end
        sb_push("reset_mid", EXP_ZERO);
        @(negedge clk_50);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({l1, l2, r1, r2, duty_cycle, lost, state_dbg} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %b/%0d lost=%b st=%0d expected all 0",
                     {l1, l2, r1, r2}, duty_cycle, lost, state_dbg);
        end
        enable = 1'b0;
        @(negedge clk_50);
        rst_n = 1'b1;
        wait_ticks(4);
        sb_push("reenable_follow", EXP_FOLLOW);
        enable = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_steering;
        sb_push("turn_l", EXP_TURN_L);
        sensor = 3'b110;
        wait_ticks(5);
        n_tests++;
        if (state_dbg !== TURN_L) begin
            n_fail++;
            $display("FAIL turn_l_state: got %0d expected %0d", state_dbg, TURN_L);
        end
        sb_push("back_follow", EXP_FOLLOW);
        sensor = 3'b010;
        wait_ticks(5);
        sensor = 3'b100;
        repeat (TICK_CLKS) @(negedge clk_50);
        sensor = 3'b010;
        wait_ticks(5);
        n_tests++;
        if (state_dbg !== FOLLOW) begin
            n_fail++;
            $display("FAIL glitch_state: got %0d expected %0d", state_dbg, FOLLOW);
        end
    endtask

    task automatic test_node;
        fork
            begin
                sensor = 3'b111;
                repeat (3 * TICK_CLKS) @(negedge clk_50);
                sensor = 3'b010;
            end
            begin
                int k;
                k = 0;
                while (state_dbg !== NODE && k < 60) begin
                    @(negedge clk_50);
                    k++;
                end
                n_tests++;
                if (state_dbg !== NODE || node_count !== 8'd1) begin
                    n_fail++;
                    $display("FAIL node_entry: got st=%0d node=%0d expected st=%0d node=1",
                             state_dbg, node_count, NODE);
                end
                k = 0;
                while (state_dbg === NODE && k < 100) begin
                    @(negedge clk_50);
                    k++;
                end
                n_tests++;
                if (k !== HOLD_T * TICK_CLKS || state_dbg !== FOLLOW) begin
                    n_fail++;
                    $display("FAIL node_hold: got %0d clk then st=%0d expected %0d clk then st=%0d",
                             k, state_dbg, HOLD_T * TICK_CLKS, FOLLOW);
                end
            end
        join
        wait_ticks(5);
    endtask

    task automatic test_saturation;
        for (int n = 2; n <= 256; n++) begin
            sensor = 3'b111;
            wait_ticks(3);
            sensor = 3'b010;
            wait_ticks(7);
            if (n == 255 || n == 256) begin
                n_tests++;
                if (node_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL node_sat_%0d: got %0d expected 255", n, node_count);
                end
            end
        end
    endtask

    task automatic test_lost;
        int k;
        sb_push("turn_r", EXP_TURN_R);
        sensor = 3'b011;
        wait_ticks(5);
        sb_push("pivot_r", EXP_PIV_R);
        sb_push("stop", EXP_ZERO);
        sensor = 3'b000;
        k = 0;
        while (state_dbg !== SEARCH && k < 80) begin
            @(negedge clk_50);
            k++;
        end
        k = 0;
        while (state_dbg === SEARCH && k < 200) begin
            @(negedge clk_50);
            k++;
        end
        n_tests++;
        if (k !== LOST_T * TICK_CLKS || state_dbg !== STOP) begin
            n_fail++;
            $display("FAIL search_timeout: got %0d clk then st=%0d expected %0d clk then st=%0d",
                     k, state_dbg, LOST_T * TICK_CLKS, STOP);
        end
        repeat (2) @(negedge clk_50);
        n_tests++;
        if (lost !== 1'b1) begin
            n_fail++;
            $display("FAIL lost_set: got %b expected 1", lost);
        end
        enable = 1'b0;
        repeat (3) @(negedge clk_50);
        n_tests++;
        if (lost !== 1'b0 || state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL lost_clear: got lost=%b st=%0d expected lost=0 st=0", lost, state_dbg);
        end
        sensor = 3'b010;
        wait_ticks(4);
        sb_push("resume_follow", EXP_FOLLOW);
        enable = 1'b1;
        wait_ticks(4);
        sb_push("turn_l2", EXP_TURN_L);
        sensor = 3'b100;
        wait_ticks(5);
        sb_push("pivot_l", EXP_PIV_L);
        sb_push("restored", EXP_FOLLOW);
        sensor = 3'b000;
        k = 0;
        while (state_dbg !== SEARCH && k < 80) begin
            @(negedge clk_50);
            k++;
        end
        repeat (25) @(negedge clk_50);
        sensor = 3'b010;
        k = 0;
        while (state_dbg === SEARCH && k < 100) begin
            @(negedge clk_50);
            k++;
        end
        n_tests++;
        if (state_dbg !== FOLLOW || lost !== 1'b0) begin
            n_fail++;
            $display("FAIL line_restored: got st=%0d lost=%b expected st=%0d lost=0",
                     state_dbg, lost, FOLLOW);
        end
        wait_ticks(3);
    endtask

    task automatic test_abort;
        int k;
        sensor = 3'b111;
        k = 0;
        while (state_dbg !== NODE && k < 60) begin
            @(negedge clk_50);
            k++;
        end
        sb_push("abort_zero", EXP_ZERO);
        enable = 1'b0;
        @(negedge clk_50);
        n_tests++;
        if (state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL abort_node: got st=%0d expected %0d", state_dbg, IDLE);
        end
        sensor = 3'b010;
        wait_ticks(3);
    endtask

    initial begin
        test_reset;
        test_steering;
        test_node;
        test_saturation;
        test_lost;
        test_abort;
        wait_ticks(3);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expect: got %0d outstanding expected 0", sb_q.size());
        end
        n_tests++;
        if (inv_viol != 0) begin
            n_fail++;
            $display("FAIL pin_duty_invariant: got %0d violations expected 0", inv_viol);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
